// File: rtl/power_mon_pkg.sv
// Shared types and defaults for the power activity monitor.
// ACT_ONES_COUNT_EN adds the ones field to the result record.
package power_mon_pkg;

  localparam int DEF_N_IN    = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_WIN_LEN = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] in_tog;
    logic [DEF_CNT_W-1:0] out_tog;
    logic [DEF_CNT_W-1:0] samples;
`ifdef ACT_ONES_COUNT_EN
    logic [DEF_CNT_W-1:0] ones;
`endif
  } mon_result_t;

endpackage

// File: rtl/sat_popcount_acc.sv
// Combinational saturating accumulate: acc_next = min(acc + popcount(a ^ b), 2^CNT_W-1).
module sat_popcount_acc #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] acc,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [CNT_W-1:0] acc_next
);

  localparam int SUM_W = CNT_W + $clog2(N + 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [SUM_W-1:0] pc;
  logic [SUM_W-1:0] sum;

  always_comb begin
    pc = '0;
    for (int i = 0; i < N; i++) begin
      pc = pc + SUM_W'(a[i] ^ b[i]);
    end
    sum      = SUM_W'(acc) + pc;
    acc_next = (sum > SUM_W'(MAX)) ? MAX : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/power_activity_monitor.sv
// Windowed toggle-activity monitor with a valid/ready result record.
// Optional macro ACT_ONES_COUNT_EN adds the res_ones output.
// state  | meaning
// IDLE   | waiting for start; counters held clear
// ACCUM  | counting toggles over WIN_LEN valid samples
// REPORT | result record offered until res_ready
module power_activity_monitor
  import power_mon_pkg::*;
#(
  parameter int N_IN    = DEF_N_IN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN_LEN = DEF_WIN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             out_bit,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_in_tog,
  output logic [CNT_W-1:0] res_out_tog,
  output logic [CNT_W-1:0] res_samples,
`ifdef ACT_ONES_COUNT_EN
  output logic [CNT_W-1:0] res_ones,
`endif
  output logic             overrun
);

  mon_state_e state_q, state_d;

  logic [CNT_W-1:0] samples_q, samples_d, in_tog_q, in_tog_d, out_tog_q, out_tog_d;
  logic [N_IN-1:0]  last_vec_q, last_vec_d;
  logic             last_bit_q, last_bit_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] res_in_tog_q, res_in_tog_d, res_out_tog_q, res_out_tog_d;
  logic [CNT_W-1:0] res_samples_q, res_samples_d;
  logic             res_valid_q, res_valid_d;
  logic             overrun_q, overrun_d;

  // start in ACCUM restarts the window, so the same-cycle sample sees cleared counters
  logic [CNT_W-1:0] samples_base, in_tog_base, out_tog_base, in_tog_inc, out_tog_inc;
  logic             first;

  assign samples_base = start ? '0 : samples_q;
  assign in_tog_base  = start ? '0 : in_tog_q;
  assign out_tog_base = start ? '0 : out_tog_q;
  assign first        = start | ~seen_q;

  sat_popcount_acc #(.N(N_IN), .CNT_W(CNT_W)) u_in_acc (
    .acc      (in_tog_base),
    .a        (in_vec),
    .b        (last_vec_q),
    .acc_next (in_tog_inc)
  );

  sat_popcount_acc #(.N(1), .CNT_W(CNT_W)) u_out_acc (
    .acc      (out_tog_base),
    .a        (out_bit),
    .b        (last_bit_q),
    .acc_next (out_tog_inc)
  );

`ifdef ACT_ONES_COUNT_EN
  logic [CNT_W-1:0] ones_q, ones_d, ones_base, ones_inc, res_ones_q, res_ones_d;

  assign ones_base = start ? '0 : ones_q;

  sat_popcount_acc #(.N(1), .CNT_W(CNT_W)) u_ones_acc (
    .acc      (ones_base),
    .a        (out_bit),
    .b        (1'b0),
    .acc_next (ones_inc)
  );
`endif

  always_comb begin
    state_d       = state_q;
    samples_d     = samples_q;
    in_tog_d      = in_tog_q;
    out_tog_d     = out_tog_q;
    last_vec_d    = last_vec_q;
    last_bit_d    = last_bit_q;
    seen_d        = seen_q;
    res_in_tog_d  = res_in_tog_q;
    res_out_tog_d = res_out_tog_q;
    res_samples_d = res_samples_q;
    res_valid_d   = res_valid_q;
    overrun_d     = overrun_q;
`ifdef ACT_ONES_COUNT_EN
    ones_d        = ones_q;
    res_ones_d    = res_ones_q;
`endif
    unique case (state_q)
      IDLE: begin
        samples_d = '0;
        in_tog_d  = '0;
        out_tog_d = '0;
        seen_d    = 1'b0;
`ifdef ACT_ONES_COUNT_EN
        ones_d    = '0;
`endif
        // a sample arriving with start is dropped, so it still flags overrun
        if (start) begin
          state_d   = ACCUM;
          overrun_d = in_valid;
        end else if (in_valid) begin
          overrun_d = 1'b1;
        end
      end
      ACCUM: begin
        samples_d = samples_base;
        in_tog_d  = in_tog_base;
        out_tog_d = out_tog_base;
        seen_d    = seen_q & ~start;
`ifdef ACT_ONES_COUNT_EN
        ones_d    = ones_base;
`endif
        if (in_valid) begin
          samples_d  = samples_base + CNT_W'(1);
          last_vec_d = in_vec;
          last_bit_d = out_bit;
          seen_d     = 1'b1;
`ifdef ACT_ONES_COUNT_EN
          ones_d     = ones_inc;
`endif
          if (!first) begin
            in_tog_d  = in_tog_inc;
            out_tog_d = out_tog_inc;
          end
          if (samples_d == CNT_W'(WIN_LEN)) begin
            res_in_tog_d  = in_tog_d;
            res_out_tog_d = out_tog_d;
            res_samples_d = samples_d;
`ifdef ACT_ONES_COUNT_EN
            res_ones_d    = ones_d;
`endif
            res_valid_d   = 1'b1;
            state_d       = REPORT;
          end
        end
      end
      REPORT: begin
        if (in_valid) overrun_d = 1'b1;
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      samples_q     <= '0;
      in_tog_q      <= '0;
      out_tog_q     <= '0;
      last_vec_q    <= '0;
      last_bit_q    <= 1'b0;
      seen_q        <= 1'b0;
      res_in_tog_q  <= '0;
      res_out_tog_q <= '0;
      res_samples_q <= '0;
      res_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef ACT_ONES_COUNT_EN
      ones_q        <= '0;
      res_ones_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      samples_q     <= samples_d;
      in_tog_q      <= in_tog_d;
      out_tog_q     <= out_tog_d;
      last_vec_q    <= last_vec_d;
      last_bit_q    <= last_bit_d;
      seen_q        <= seen_d;
      res_in_tog_q  <= res_in_tog_d;
      res_out_tog_q <= res_out_tog_d;
      res_samples_q <= res_samples_d;
      res_valid_q   <= res_valid_d;
      overrun_q     <= overrun_d;
`ifdef ACT_ONES_COUNT_EN
      ones_q        <= ones_d;
      res_ones_q    <= res_ones_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign res_valid   = res_valid_q;
  assign res_in_tog  = res_in_tog_q;
  assign res_out_tog = res_out_tog_q;
  assign res_samples = res_samples_q;
  assign overrun     = overrun_q;
`ifdef ACT_ONES_COUNT_EN
  assign res_ones    = res_ones_q;
`endif

endmodule

// File: tb/tb_power_activity_monitor.sv
// Bench for power_activity_monitor: two configurations share stimulus; a window-level
// model checks both every cycle, plus directed tables and corner-case sequences.
module tb_power_activity_monitor;
  import power_mon_pkg::*;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_bit, res_ready;
  logic [3:0] in_vec;

  logic b0, rv0, ovr0, b1, rv1, ovr1;
  logic [15:0] it0, ot0, sm0;
  logic [3:0]  it1, ot1, sm1;
`ifdef ACT_ONES_COUNT_EN
  logic [15:0] on0;
  logic [3:0]  on1;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  power_activity_monitor #(.N_IN(4), .CNT_W(16), .WIN_LEN(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec),
    .out_bit(out_bit), .busy(b0), .res_valid(rv0), .res_ready(res_ready),
    .res_in_tog(it0), .res_out_tog(ot0), .res_samples(sm0),
`ifdef ACT_ONES_COUNT_EN
    .res_ones(on0),
`endif
    .overrun(ovr0)
  );

  power_activity_monitor #(.N_IN(4), .CNT_W(4), .WIN_LEN(15)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_vec(in_vec),
    .out_bit(out_bit), .busy(b1), .res_valid(rv1), .res_ready(res_ready),
    .res_in_tog(it1), .res_out_tog(ot1), .res_samples(sm1),
`ifdef ACT_ONES_COUNT_EN
    .res_ones(on1),
`endif
    .overrun(ovr1)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // ---------------- window-level reference model ----------------
  int mode[2], ovr_m[2], rv_m[2], rin[2], rout[2], rsmp[2], rones[2];
  int q0[$], q1[$];

  function automatic int wl(int d);
    return (d == 0) ? 4 : 15;
  endfunction

  function automatic int cmax(int d);
    return (d == 0) ? 65535 : 15;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mode[d] = 0; ovr_m[d] = 0; rv_m[d] = 0;
      rin[d] = 0; rout[d] = 0; rsmp[d] = 0; rones[d] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(int d);
    int w[$];
    int ti, to, on;
    if (d == 0) w = q0; else w = q1;
    case (mode[d])
      0: begin
        if (start) begin mode[d] = 1; w.delete(); ovr_m[d] = int'(in_valid); end
        else if (in_valid) ovr_m[d] = 1;
      end
      1: begin
        if (start) w.delete();
        if (in_valid) begin
          w.push_back({27'd0, out_bit, in_vec});
          if (w.size() == wl(d)) begin
            ti = 0; to = 0; on = 0;
            for (int i = 0; i < w.size(); i++) begin
              if (w[i][4]) on++;
              if (i > 0) begin
                ti += $countones(w[i][3:0] ^ w[i-1][3:0]);
                to += int'(w[i][4] ^ w[i-1][4]);
              end
            end
            rin[d]   = (ti > cmax(d)) ? cmax(d) : ti;
            rout[d]  = (to > cmax(d)) ? cmax(d) : to;
            rones[d] = (on > cmax(d)) ? cmax(d) : on;
            rsmp[d]  = w.size();
            rv_m[d]  = 1;
            mode[d]  = 2;
          end
        end
      end
      default: begin
        if (in_valid) ovr_m[d] = 1;
        if (res_ready) begin rv_m[d] = 0; mode[d] = 0; end
      end
    endcase
    if (d == 0) q0 = w; else q1 = w;
  endtask

  task automatic model_check(int d);
    int ab, arv, aov, ai, ao, asm, aon;
    if (d == 0) begin
      ab = int'(b0); arv = int'(rv0); aov = int'(ovr0);
      ai = int'(it0); ao = int'(ot0); asm = int'(sm0); aon = 0;
`ifdef ACT_ONES_COUNT_EN
      aon = int'(on0);
`endif
    end else begin
      ab = int'(b1); arv = int'(rv1); aov = int'(ovr1);
      ai = int'(it1); ao = int'(ot1); asm = int'(sm1); aon = 0;
`ifdef ACT_ONES_COUNT_EN
      aon = int'(on1);
`endif
    end
    chk($sformatf("model u%0d busy", d), ab, int'(mode[d] != 0));
    chk($sformatf("model u%0d res_valid", d), arv, rv_m[d]);
    chk($sformatf("model u%0d overrun", d), aov, ovr_m[d]);
    chk($sformatf("model u%0d res_in_tog", d), ai, rin[d]);
    chk($sformatf("model u%0d res_out_tog", d), ao, rout[d]);
    chk($sformatf("model u%0d res_samples", d), asm, rsmp[d]);
`ifdef ACT_ONES_COUNT_EN
    chk($sformatf("model u%0d res_ones", d), aon, rones[d]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin model_step(0); model_step(1); end
    #1;
    model_check(0);
    model_check(1);
  endtask

  task automatic drv(bit st, bit iv, logic [3:0] v, bit ob, bit rd);
    start = st; in_valid = iv; in_vec = v; out_bit = ob; res_ready = rd;
  endtask

  task automatic run_basic();
    drv(1, 0, 4'h0, 0, 0); tick();
    drv(0, 1, 4'h0, 0, 0); tick();
    drv(0, 1, 4'h1, 1, 0); tick();
    drv(0, 1, 4'h3, 1, 0); tick();
    chk("basic res_valid before 4th", int'(rv0), 0);
    drv(0, 1, 4'h3, 0, 0); tick();
  endtask

  task automatic chk_basic(string nm);
    chk({nm, " res_valid"}, int'(rv0), 1);
    chk({nm, " res_in_tog"}, int'(it0), 2);
    chk({nm, " res_out_tog"}, int'(ot0), 2);
    chk({nm, " res_samples"}, int'(sm0), 4);
`ifdef ACT_ONES_COUNT_EN
    chk({nm, " res_ones"}, int'(on0), 2);
`endif
  endtask

  task automatic drain();
    drv(0, 0, 4'h0, 0, 1);
    repeat (2) tick();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit st, iv;
    logic [3:0] v;
    bit ob, rd;
    bit e_busy, e_rv;
    mon_result_t e_res;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit st, bit iv, logic [3:0] v, bit ob, bit rd, bit eb, bit erv);
    vec_t r;
    r.st = st; r.iv = iv; r.v = v; r.ob = ob; r.rd = rd;
    r.e_busy = eb; r.e_rv = erv;
    r.e_res.in_tog  = 16'd2;
    r.e_res.out_tog = 16'd2;
    r.e_res.samples = 16'd4;
`ifdef ACT_ONES_COUNT_EN
    r.e_res.ones    = 16'd2;
`endif
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drv(0, 0, 4'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(b0), 0);
    chk("reset res_valid", int'(rv0), 0);
    chk("reset overrun", int'(ovr0), 0);
    chk("reset res_in_tog", int'(it0), 0);
    chk("reset res_samples u1", int'(sm1), 0);
    rst = 1'b0;

    // back-to-back window, then same samples with gaps carrying junk values
    tv.push_back(mk(1, 0, 4'h0, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 4'h0, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 4'h1, 1, 0, 1, 0));
    tv.push_back(mk(0, 1, 4'h3, 1, 0, 1, 0));
    tv.push_back(mk(0, 1, 4'h3, 0, 0, 1, 1));
    tv.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0));
    tv.push_back(mk(1, 0, 4'h0, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 4'h0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 4'hF, 1, 0, 1, 0));
    tv.push_back(mk(0, 1, 4'h1, 1, 0, 1, 0));
    tv.push_back(mk(0, 0, 4'hC, 0, 0, 1, 0));
    tv.push_back(mk(0, 1, 4'h3, 1, 0, 1, 0));
    tv.push_back(mk(0, 0, 4'hF, 1, 0, 1, 0));
    tv.push_back(mk(0, 1, 4'h3, 0, 0, 1, 1));
    tv.push_back(mk(0, 0, 4'h0, 0, 1, 0, 0));
    for (int i = 0; i < tv.size(); i++) begin
      drv(tv[i].st, tv[i].iv, tv[i].v, tv[i].ob, tv[i].rd);
      tick();
      chk($sformatf("tbl[%0d] busy", i), int'(b0), int'(tv[i].e_busy));
      chk($sformatf("tbl[%0d] res_valid", i), int'(rv0), int'(tv[i].e_rv));
      if (tv[i].e_rv) begin
        chk($sformatf("tbl[%0d] res_in_tog", i), int'(it0), int'(tv[i].e_res.in_tog));
        chk($sformatf("tbl[%0d] res_out_tog", i), int'(ot0), int'(tv[i].e_res.out_tog));
        chk($sformatf("tbl[%0d] res_samples", i), int'(sm0), int'(tv[i].e_res.samples));
`ifdef ACT_ONES_COUNT_EN
        chk($sformatf("tbl[%0d] res_ones", i), int'(on0), int'(tv[i].e_res.ones));
`endif
      end
    end

    // backpressure with overrun, handshake, overrun cleared by next start
    drain();
    run_basic();
    for (int i = 0; i < 10; i++) begin
      drv(0, 1, 4'($urandom), 1'($urandom), 0);
      tick();
      chk_basic("stall");
      chk("stall overrun", int'(ovr0), 1);
      chk("stall busy", int'(b0), 1);
    end
    drv(0, 0, 4'h0, 0, 1); tick();
    chk("handshake res_valid", int'(rv0), 0);
    chk("handshake busy", int'(b0), 0);
    chk("handshake overrun kept", int'(ovr0), 1);
    drv(1, 0, 4'h0, 0, 0); tick();
    chk("start clears overrun", int'(ovr0), 0);

    // saturation on the narrow instance: 56 true toggles, 14 output toggles
    drain();
    drv(1, 0, 4'h0, 0, 0); tick();
    for (int i = 0; i < 15; i++) begin
      drv(0, 1, (i % 2 != 0) ? 4'hF : 4'h0, (i % 2 != 0), 0);
      tick();
      if (i == 13) chk("sat res_valid before 15th", int'(rv1), 0);
    end
    chk("sat res_valid", int'(rv1), 1);
    chk("sat res_in_tog", int'(it1), 15);
    chk("sat res_out_tog", int'(ot1), 14);
    chk("sat res_samples", int'(sm1), 15);
`ifdef ACT_ONES_COUNT_EN
    chk("sat res_ones", int'(on1), 7);
`endif

    // restart mid-window; the restart cycle carries the new first sample
    drain();
    drv(1, 0, 4'h0, 0, 0); tick();
    drv(0, 1, 4'h5, 1, 0); tick();
    drv(0, 1, 4'hA, 0, 0); tick();
    drv(1, 1, 4'h0, 0, 0); tick();
    drv(0, 1, 4'h1, 1, 0); tick();
    drv(0, 1, 4'h3, 1, 0); tick();
    chk("restart res_valid early", int'(rv0), 0);
    drv(0, 1, 4'h3, 0, 0); tick();
    chk_basic("restart");

    // async reset while reporting
    drain();
    run_basic();
    chk("pre-rst res_valid", int'(rv0), 1);
    drv(0, 0, 4'h0, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("async rst busy", int'(b0), 0);
    chk("async rst res_valid", int'(rv0), 0);
    chk("async rst res_in_tog", int'(it0), 0);
    chk("async rst res_out_tog", int'(ot0), 0);
    chk("async rst res_samples", int'(sm0), 0);
    chk("async rst u1 busy", int'(b1), 0);
    tick();
    rst = 1'b0;
    run_basic();
    chk_basic("post-rst");
    chk("post-rst overrun", int'(ovr0), 0);

    // randomized traffic against the model
    drain();
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
          1'($urandom), $urandom_range(0, 4) < 2);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
